// File: rtl/weights_stream_memory_pkg.sv
// Shared defaults and FSM encoding for the weights streaming memory.
package weights_stream_memory_pkg;
  localparam int DEF_DATA_WIDTH = 5;
  localparam int DEF_LANES      = 3;
  localparam int DEF_ADDR_DEPTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FINISH = 2'd2
  } state_t;
endpackage

// File: rtl/weights_stream_memory_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module weights_ram #(
  parameter int WIDTH      = 15,
  parameter int ADDR_DEPTH = 12
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);
  logic [WIDTH-1:0] mem [2**ADDR_DEPTH];

  // NOTE: no reset on the array so it maps to block RAM; both ports use <=,
  // so a same-address read and write returns the pre-write content.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/weights_stream_memory.sv
// Burst reader streaming packed weight words out of an internal RAM with
// valid/ready flow control; the write port is usable in every state.
module weights_stream_memory
  import weights_stream_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_DEPTH = DEF_ADDR_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_DEPTH-1:0]       wr_addr,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  input  logic                        start,
  input  logic [ADDR_DEPTH-1:0]       base_addr,
  input  logic [ADDR_DEPTH:0]         burst_len,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] data_out,
  output logic                        data_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int WORD_W = LANES * DATA_WIDTH;
  localparam logic [ADDR_DEPTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_DEPTH:0]   REM_ONE  = 1;

  state_t                state, state_next;
  logic [ADDR_DEPTH-1:0] cur_addr, addr_next;
  logic [ADDR_DEPTH:0]   remaining, rem_next;
  logic                  valid_next;
  logic                  rd_en;
  logic                  can_advance;
  logic [WORD_W-1:0]     ram_q;

  weights_ram #(
    .WIDTH      (WORD_W),
    .ADDR_DEPTH (ADDR_DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (cur_addr),
    .rd_data (ram_q)
  );

  // The output slot is free when empty or being drained this cycle.
  assign can_advance = !data_valid || out_ready;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    addr_next  = cur_addr;
    rem_next   = remaining;
    valid_next = data_valid;
    rd_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_next  = base_addr;
          rem_next   = burst_len;
          state_next = READ;
        end
      end
      READ: begin
        if (can_advance) begin
          if (remaining != '0) begin
            rd_en      = 1'b1;
            addr_next  = cur_addr + ADDR_ONE;
            rem_next   = remaining - REM_ONE;
            valid_next = 1'b1;
          end else begin
            valid_next = 1'b0;
            state_next = FINISH;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_next;
      cur_addr   <= addr_next;
      remaining  <= rem_next;
      data_valid <= valid_next;
    end
  end

  // The RAM read register holds during stalls; gating with data_valid gives
  // zeros when empty and after reset without resetting the RAM.
  assign data_out = data_valid ? ram_q : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
endmodule

// File: tb/tb_weights_stream_memory.sv
// Directed bench for weights_stream_memory with hand-computed expectations.
module tb_weights_stream_memory;
  localparam int W  = 15;
  localparam int AD = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AD-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [AD-1:0] base_addr;
  logic [AD:0]   burst_len;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_beats [4];

  weights_stream_memory dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .base_addr  (base_addr),
    .burst_len  (burst_len),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [AD-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_burst(input logic [AD-1:0] b, input logic [AD:0] n);
    base_addr = b; burst_len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full-rate burst of up to 4 beats, checking each beat and the done pulse.
  task automatic stream_burst(input string tag, input logic [AD-1:0] b, input logic [AD:0] n);
    start_burst(b, n);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_nolat"}, 32'(data_valid), 32'd0);
    for (int i = 0; i < int'(n); i++) begin
      tick();
      check($sformatf("%s_v%0d", tag, i), 32'(data_valid), 32'd1);
      check($sformatf("%s_d%0d", tag, i), 32'(data_out), 32'(exp_beats[i]));
      check($sformatf("%s_nd%0d", tag, i), 32'(done), 32'd0);
    end
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_endv"}, 32'(data_valid), 32'd0);
    check({tag, "_endd"}, 32'(data_out), 32'd0);
    tick();
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; base_addr = '0; burst_len = '0; out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    write_word(12'd0,    15'h0101);
    write_word(12'd1,    15'h0202);
    write_word(12'd2,    15'h0303);
    write_word(12'd3,    15'h0404);
    write_word(12'd5,    15'h0505);
    write_word(12'd4094, 15'h0AAA);
    write_word(12'd4095, 15'h0BBB);

    // basic full-rate burst
    exp_beats = '{15'h0101, 15'h0202, 15'h0303, 15'h0404};
    stream_burst("basic", 12'd0, 13'd4);

    // address wrap
    exp_beats = '{15'h0AAA, 15'h0BBB, 15'h0101, 15'h0202};
    stream_burst("wrap", 12'd4094, 13'd4);

    // back-pressure for three cycles after the second beat
    start_burst(12'd0, 13'd4);
    tick();
    check("bp_d0", 32'(data_out), 32'h0101);
    tick();
    check("bp_d1", 32'(data_out), 32'h0202);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_v%0d", i), 32'(data_valid), 32'd1);
      check($sformatf("bp_hold_d%0d", i), 32'(data_out), 32'h0202);
    end
    out_ready = 1'b1;
    tick();
    check("bp_d2", 32'(data_out), 32'h0303);
    tick();
    check("bp_d3", 32'(data_out), 32'h0404);
    check("bp_v3", 32'(data_valid), 32'd1);
    tick();
    check("bp_done", 32'(done), 32'd1);
    tick();
    check("bp_idle", 32'(busy), 32'd0);

    // zero-length burst: busy for READ and FINISH only
    start_burst(12'd0, 13'd0);
    check("z_busy1", 32'(busy), 32'd1);
    check("z_v1",    32'(data_valid), 32'd0);
    check("z_done1", 32'(done), 32'd0);
    tick();
    check("z_busy2", 32'(busy), 32'd1);
    check("z_v2",    32'(data_valid), 32'd0);
    check("z_done2", 32'(done), 32'd1);
    tick();
    check("z_busy3", 32'(busy), 32'd0);
    check("z_done3", 32'(done), 32'd0);

    // write and read the same address in the same cycle
    start_burst(12'd5, 13'd1);
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = 15'h7FFF;
    tick();
    wr_en = 1'b0;
    check("col_old", 32'(data_out), 32'h0505);
    tick();
    check("col_done", 32'(done), 32'd1);
    tick();
    exp_beats[0] = 15'h7FFF;
    stream_burst("col_new", 12'd5, 13'd1);

    // asynchronous reset mid-burst
    start_burst(12'd0, 13'd4);
    tick();
    tick();
    check("ab_pre_v", 32'(data_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ab_v",    32'(data_valid), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_data", 32'(data_out), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    tick();
    check("ab_done_hold", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    check("ab_post_done", 32'(done), 32'd0);
    check("ab_post_busy", 32'(busy), 32'd0);
    exp_beats = '{15'h0101, 15'h0202, 15'h0303, 15'h0404};
    stream_burst("keep", 12'd0, 13'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weights_stream_memory.md
WEIGHTS_STREAM_MEMORY -- requirements
Module: weights_stream_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, bits per signed weight lane.
REQ-002 SHALL have parameter LANES, default 3, weights per memory word.
REQ-003 SHALL have parameter ADDR_DEPTH, default 12, address bits; depth = 2**ADDR_DEPTH words.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  write strobe.
REQ-007 SHALL have port wr_addr  in  ADDR_DEPTH  write address.
REQ-008 SHALL have port wr_data  in  LANES*DATA_WIDTH  write word; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port start  in  1  burst request, sampled only in IDLE.
REQ-010 SHALL have port base_addr  in  ADDR_DEPTH  first burst address.
REQ-011 SHALL have port burst_len  in  ADDR_DEPTH+1  number of words, 0..2**ADDR_DEPTH.
REQ-012 SHALL have port out_ready  in  1  consumer accepts data_out this cycle.
REQ-013 SHALL have port data_out  out  LANES*DATA_WIDTH  registered read word, same lane packing.
REQ-014 SHALL have port data_valid  out  1  data_out holds an unconsumed word.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement FSM states IDLE, READ, FINISH.
REQ-018 SHALL, in IDLE with start=1, latch cur_addr=base_addr and remaining=burst_len, then enter READ; start in other states is ignored.
REQ-019 SHALL, in READ, issue a read when remaining>0 and (data_valid=0 or out_ready=1): data_out<=M[cur_addr], data_valid<=1, cur_addr+1, remaining-1.
REQ-020 SHALL give exactly one cycle latency from read issue to data_valid.
REQ-021 SHALL clear data_valid when data_valid=1, out_ready=1 and no read is issued that cycle.
REQ-022 SHALL hold data_out and data_valid stable while data_valid=1 and out_ready=0.
REQ-023 SHALL wrap cur_addr from 2**ADDR_DEPTH-1 to 0.
REQ-024 SHALL enter FINISH when remaining=0 and (data_valid=0 or out_ready=1); FINISH asserts done for one cycle and returns to IDLE.
REQ-025 SHALL treat burst_len=0 as READ for one cycle, then FINISH, with no beats.
REQ-026 SHALL drive data_out to all zeros when data_valid=0 (no tri-state).
REQ-027 SHALL write M[wr_addr]<=wr_data on any rising edge with wr_en=1, in every state.
REQ-028 SHALL return the old content when read and write hit the same address in the same cycle.

Reset
REQ-029 SHALL, on reset, force state IDLE, data_valid=0, data_out=0, busy=0, done=0, cur_addr=0, remaining=0.
REQ-030 SHALL abort an in-progress burst on reset with no done pulse.
REQ-031 SHALL not clear memory contents on reset.

Structure
REQ-032 SHALL take FSM state encodings and default DATA_WIDTH/LANES/ADDR_DEPTH from the shared package.
REQ-033 SHALL place the storage array in sub-module weights_ram (write port plus registered read port, no reset).

Verification
REQ-034 SHALL: write words 0..3 = 0x0101,0x0202,0x0303,0x0404; start base=0 len=4, out_ready=1 -> valid beats 0x0101..0x0404 on consecutive cycles, done one cycle after last beat.
REQ-035 SHALL: base=4094 len=4 (ADDR_DEPTH=12) -> beats from addresses 4094,4095,0,1.
REQ-036 SHALL: out_ready=0 for 3 cycles mid-burst -> data_out held, no beat lost or duplicated.
REQ-037 SHALL: len=0 -> no data_valid, done pulse, busy high exactly 2 cycles.
REQ-038 SHALL: write 0x7FFF to address 5 while reading address 5 -> old value returned, next burst returns 0x7FFF.
REQ-039 SHALL: reset asserted mid-burst -> data_valid=0, busy=0 asynchronously, no done, memory contents preserved.
